avlst_vga_out: RTL and testbench

AVLST_VGA_OUT -- requirements
Module: avlst_vga_out

---
 rtl/avlst_if.sv | 13 +
 rtl/avlst_vga_out.sv | 153 +++++++++++++++
 tb/tb_avlst_vga_out.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/avlst_if.sv
// Avalon-ST style pixel stream interface: sink drives ready, source drives the rest.
interface avlst_if #(
  parameter int DATA_BYTES = 4
);
  logic [8*DATA_BYTES-1:0] data;
  logic                    valid;
  logic                    ready;
  logic                    startofpacket;
  logic                    endofpacket;

  modport master (output data, valid, startofpacket, endofpacket, input ready);
  modport slave  (input data, valid, startofpacket, endofpacket, output ready);
endinterface

// File: rtl/avlst_vga_out.sv
// Streams Avalon-ST pixels into a small FIFO and replays them on a VGA raster,
// locking onto startofpacket and dropping back to search on underflow or misalignment.
module avlst_vga_out #(
  parameter int HDISP      = 800,
  parameter int VDISP      = 480,
  parameter int HFP        = 40,
  parameter int HPULSE     = 48,
  parameter int HBP        = 40,
  parameter int VFP        = 13,
  parameter int VPULSE     = 3,
  parameter int VBP        = 29,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        nrst,
  avlst_if.slave      avs,
  output logic [23:0] vga_rgb,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_n,
  output logic        frame_lock,
  output logic        underflow
);
  localparam int HTOTAL = HDISP + HFP + HPULSE + HBP;
  localparam int VTOTAL = VDISP + VFP + VPULSE + VBP;
  localparam int HW     = $clog2(HTOTAL);
  localparam int VW     = $clog2(VTOTAL);
  localparam int AW     = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {SEARCH, WAIT, RUN} state_t;
  typedef struct packed {
    logic        sop;
    logic [23:0] rgb;
  } word_t;

  state_t        state_q, state_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  word_t         mem_q [FIFO_DEPTH];
  word_t         head;
  logic [23:0]   rgb_q, rgb_d;
  logic          hs_q, vs_q, blank_q, uf_q, uf_d;
  logic          h_last, v_last, active, origin, frame_end, hs_act, vs_act;
  logic          full, empty, accept, wr_en, pop, flush;
  logic          unused_bits;

  assign unused_bits = ^{avs.endofpacket, avs.data[31:24]};

  assign h_last    = (int'(h_q) == HTOTAL - 1);
  assign v_last    = (int'(v_q) == VTOTAL - 1);
  assign frame_end = h_last && v_last;
  assign h_d       = h_last ? '0 : h_q + 1'b1;
  assign v_d       = h_last ? (v_last ? '0 : v_q + 1'b1) : v_q;
  assign active    = (int'(h_q) < HDISP) && (int'(v_q) < VDISP);
  assign origin    = (h_q == '0) && (v_q == '0);
  assign hs_act    = (int'(h_q) >= HDISP + HFP) && (int'(h_q) < HDISP + HFP + HPULSE);
  assign vs_act    = (int'(v_q) >= VDISP + VFP) && (int'(v_q) < VDISP + VFP + VPULSE);

  // Extra pointer bit distinguishes full from empty.
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head      = mem_q[rd_ptr_q[AW-1:0]];
  assign avs.ready = nrst && !full;
  assign accept    = avs.valid && avs.ready;

  always_comb begin
    state_d  = state_q;
    wr_en    = 1'b0;
    pop      = 1'b0;
    flush    = 1'b0;
    rgb_d    = '0;
    uf_d     = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    case (state_q)
      SEARCH: begin
        if (accept && avs.startofpacket) begin
          wr_en   = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        wr_en = accept;
        if (frame_end) state_d = RUN;
      end
      RUN: begin
        wr_en = accept;
        if (active) begin
          if (empty) begin
            uf_d    = 1'b1;
            flush   = 1'b1;
            state_d = SEARCH;
          end else begin
            pop   = 1'b1;
            rgb_d = head.rgb;
            // A frame start anywhere but (0,0), or a missing one at (0,0), means lost alignment.
            if (head.sop != origin) begin
              flush   = 1'b1;
              state_d = SEARCH;
            end
          end
        end
      end
      default: state_d = SEARCH;
    endcase
    if (flush) begin
      wr_en    = 1'b0;
      rd_ptr_d = wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_en};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= {avs.startofpacket, avs.data[23:0]};
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= SEARCH;
      h_q      <= '0;
      v_q      <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rgb_q    <= '0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      blank_q  <= 1'b0;
      uf_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      h_q      <= h_d;
      v_q      <= v_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rgb_q    <= rgb_d;
      hs_q     <= !hs_act;
      vs_q     <= !vs_act;
      blank_q  <= active;
      uf_q     <= uf_d;
    end
  end

  assign vga_rgb     = rgb_q;
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_blank_n = blank_q;
  assign underflow   = uf_q;
  assign frame_lock  = (state_q == RUN);
endmodule

// File: tb/tb_avlst_vga_out.sv
// Directed bench for avlst_vga_out on a 7x5 raster (4x2 active) with a 4-entry FIFO.
module tb_avlst_vga_out;
  localparam int HT = 7;
  localparam int VT = 5;

  logic        clk  = 1'b0;
  logic        nrst = 1'b0;
  logic [23:0] vga_rgb;
  logic        vga_hs, vga_vs, vga_blank_n, frame_lock, underflow;

  avlst_if #(.DATA_BYTES(4)) avs ();

  avlst_vga_out #(
    .HDISP(4), .VDISP(2), .HFP(1), .HPULSE(1), .HBP(1),
    .VFP(1), .VPULSE(1), .VBP(1), .FIFO_DEPTH(4)
  ) dut (
    .clk         (clk),
    .nrst        (nrst),
    .avs         (avs),
    .vga_rgb     (vga_rgb),
    .vga_hs      (vga_hs),
    .vga_vs      (vga_vs),
    .vga_blank_n (vga_blank_n),
    .frame_lock  (frame_lock),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  int          n_checks    = 0;
  int          n_errors    = 0;
  int          n_out       = -1;
  int          uf_cnt      = 0;
  int          rdy_low_cnt = 0;
  logic [24:0] src_q[$];
  logic [23:0] seen_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h (raster index %0d)", tag, got, exp, n_out);
    end
  endtask

  task automatic push_words(input int base, input int n, input int sop_mask);
    logic s;
    for (int i = 0; i < n; i++) begin
      s = ((sop_mask >> i) & 1) != 0;
      src_q.push_back({s, 24'(base + i)});
    end
  endtask

  // Called at a falling edge; drives the source, crosses one rising edge, samples at the next falling edge.
  task automatic step();
    logic acc;
    if (src_q.size() > 0) begin
      avs.valid         = 1'b1;
      avs.startofpacket = src_q[0][24];
      avs.data          = {8'h00, src_q[0][23:0]};
    end else begin
      avs.valid         = 1'b0;
      avs.startofpacket = 1'b0;
      avs.data          = '0;
    end
    #1;
    acc = avs.valid && avs.ready;
    if (avs.valid && !avs.ready) rdy_low_cnt++;
    @(posedge clk);
    if (acc) void'(src_q.pop_front());
    @(negedge clk);
    n_out++;
    if (underflow) uf_cnt++;
    if (vga_blank_n && frame_lock) seen_q.push_back(vga_rgb);
  endtask

  task automatic run_to(input int target);
    while (n_out < target) step();
  endtask

  initial begin
    int h, v, hs_bad, vs_bad, bl_bad, idle_bad, blank_cnt, uf_base, guard;
    hs_bad = 0; vs_bad = 0; bl_bad = 0; idle_bad = 0; blank_cnt = 0; guard = 0;
    avs.valid = 1'b0; avs.data = '0; avs.startofpacket = 1'b0; avs.endofpacket = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rgb", vga_rgb, 0);
    chk("rst_hs", vga_hs, 1);
    chk("rst_vs", vga_vs, 1);
    chk("rst_blank", vga_blank_n, 0);
    chk("rst_lock", frame_lock, 0);
    chk("rst_uf", underflow, 0);
    chk("rst_ready", avs.ready, 0);
    nrst = 1'b1;
    n_out = -1;
    #1 chk("ready_release", avs.ready, 1);

    // One idle frame: timing only.
    for (int k = 0; k < 35; k++) begin
      step();
      h = n_out % HT;
      v = (n_out / HT) % VT;
      if (vga_hs !== ((h == 5) ? 1'b0 : 1'b1)) hs_bad++;
      if (vga_vs !== ((v == 3) ? 1'b0 : 1'b1)) vs_bad++;
      if (vga_blank_n !== ((h < 4) && (v < 2))) bl_bad++;
      if (vga_blank_n) blank_cnt++;
      if (vga_rgb !== 24'd0 || frame_lock !== 1'b0) idle_bad++;
    end
    chk("hs_pattern", hs_bad, 0);
    chk("vs_pattern", vs_bad, 0);
    chk("blank_pattern", bl_bad, 0);
    chk("blank_count", blank_cnt, 8);
    chk("idle_rgb_lock", idle_bad, 0);

    // Lock: three junk words, then frame 1..8, then a short frame 11..15.
    push_words(24'hAA, 3, 0);
    push_words(1, 8, 1);
    push_words(11, 5, 1);
    run_to(35);
    chk("search_blank", vga_blank_n, 1);
    chk("search_rgb", vga_rgb, 0);
    run_to(68);
    chk("lock_before", frame_lock, 0);
    run_to(69);
    chk("lock_at_6_4", frame_lock, 1);
    for (int i = 0; i < 4; i++) begin
      run_to(70 + i);
      chk("px_line0", vga_rgb, 1 + i);
    end
    for (int i = 0; i < 4; i++) begin
      run_to(77 + i);
      chk("px_line1", vga_rgb, 5 + i);
    end

    // Underflow after five pixels.
    uf_base = uf_cnt;
    run_to(105);
    chk("uf_px0", vga_rgb, 11);
    run_to(112);
    chk("uf_px4", vga_rgb, 15);
    run_to(113);
    chk("uf_pulse", underflow, 1);
    chk("uf_rgb", vga_rgb, 0);
    chk("uf_unlock", frame_lock, 0);
    run_to(114);
    chk("uf_pulse_end", underflow, 0);

    // Misplaced sop on the third word of the second frame, then relock.
    push_words(21, 8, 1);
    push_words(31, 8, 5);
    push_words(41, 8, 1);
    run_to(139);
    chk("uf_once", uf_cnt - uf_base, 1);
    chk("relock_a", frame_lock, 1);
    run_to(140);
    chk("frame_a_px0", vga_rgb, 21);
    run_to(176);
    chk("frame_b_lock", frame_lock, 1);
    chk("frame_b_px1", vga_rgb, 32);
    run_to(177);
    chk("bad_sop_px", vga_rgb, 33);
    chk("bad_sop_unlock", frame_lock, 0);
    chk("bad_sop_no_uf", underflow, 0);
    run_to(208);
    chk("relock_c_before", frame_lock, 0);
    run_to(209);
    chk("relock_c", frame_lock, 1);
    run_to(210);
    chk("frame_c_px0", vga_rgb, 41);
    run_to(217);
    chk("frame_c_px4", vga_rgb, 45);
    run_to(220);
    chk("frame_c_px7", vga_rgb, 48);
    chk("uf_count_stable", uf_cnt - uf_base, 1);
    run_to(245);
    chk("uf_empty_frame", underflow, 1);
    run_to(246);

    // Always-valid source against the 4-entry FIFO.
    seen_q.delete();
    rdy_low_cnt = 0;
    for (int f = 0; f < 4; f++) push_words(256 + f * 16, 8, 1);
    repeat (3) step();
    chk("ready_at_3", avs.ready, 1);
    step();
    chk("ready_at_4", avs.ready, 0);
    while (seen_q.size() < 24 && guard < 300) begin
      step();
      guard++;
    end
    chk("collect_done", seen_q.size() >= 24, 1);
    for (int j = 0; j < 24; j++) begin
      if (j < seen_q.size()) chk("stream_px", seen_q[j], 256 + (j / 8) * 16 + (j % 8));
    end
    chk("ready_stalled", rdy_low_cnt != 0, 1);

    // Asynchronous reset while the counter sits at (2,1) in RUN.
    run_to(393);
    chk("pre_rst_lock", frame_lock, 1);
    chk("pre_rst_px", vga_rgb, 24'h135);
    #1 nrst = 1'b0;
    src_q.delete();
    avs.valid = 1'b0; avs.startofpacket = 1'b0; avs.data = '0;
    #1;
    chk("arst_rgb", vga_rgb, 0);
    chk("arst_hs", vga_hs, 1);
    chk("arst_vs", vga_vs, 1);
    chk("arst_blank", vga_blank_n, 0);
    chk("arst_lock", frame_lock, 0);
    chk("arst_uf", underflow, 0);
    chk("arst_ready", avs.ready, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
    n_out = -1;
    #1 chk("ready_release2", avs.ready, 1);
    run_to(0);
    chk("restart_blank", vga_blank_n, 1);
    chk("restart_rgb", vga_rgb, 0);
    chk("restart_search", frame_lock, 0);
    run_to(5);
    chk("restart_hs", vga_hs, 0);
    run_to(21);
    chk("restart_vs", vga_vs, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
